// File: rtl/tpu_seq_pkg.sv
// Shared types, widths and latency helper for the systolic array sequencer.
package tpu_seq_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned DEFAULT_CNT_W  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoadW,
    StWSettle,
    StStream,
    StDrain
  } state_e;

  // Skew plus accumulation latency of an n x n array, from activation valid to result row.
  function automatic int unsigned arr_lat(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/tpu_valid_delay.sv
// Shift-register delay line with synchronous clear; dout is din delayed by DEPTH cycles.
module tpu_valid_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per cycle; reset and clear flush every stage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_sequencer.sv
// Job sequencer for an N x N weight-stationary systolic array: clear, load weights,
// stream activations, write results, then pulse done.
module systolic_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     num_rows,
  input  logic [ADDR_W-1:0]    w_base,
  input  logic [ADDR_W-1:0]    a_base,
  input  logic [ADDR_W-1:0]    o_base,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd_en,
  output logic [ADDR_W-1:0]    w_rd_addr,
  output logic                 a_rd_en,
  output logic [ADDR_W-1:0]    a_rd_addr,
  output logic                 arr_clear,
  output logic                 arr_load_w,
  output logic [$clog2(N)-1:0] arr_w_row,
  output logic                 arr_act_valid,
  output logic                 o_wr_en,
  output logic [ADDR_W-1:0]    o_wr_addr
);

  localparam int unsigned ROW_W   = $clog2(N);
  localparam int unsigned ARR_LAT = arr_lat(N);
  localparam int unsigned CW      = CNT_W + 1;

  state_e state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  m_q, m_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d, a_base_q, a_base_d, o_base_q, o_base_d;
  logic [CW-1:0]     m_ext;

  logic              busy_d, done_d, arr_clear_d;
  logic              w_rd_en_d, a_rd_en_d, o_wr_en_d;
  logic [ADDR_W-1:0] w_rd_addr_d, a_rd_addr_d, o_wr_addr_d;
  logic [ROW_W-1:0]  w_rd_row_q, w_rd_row_d;
  logic              wr_pre;

  assign m_ext = {1'b0, m_q};

  // Next state, counters and the registered-output values derived from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    o_base_d = o_base_q;
    done_d   = 1'b0;
    wr_cnt_d = wr_pre ? wr_cnt_q + CW'(1) : wr_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StClear;
          cnt_d    = '0;
          wr_cnt_d = '0;
          m_d      = num_rows;
          w_base_d = w_base;
          a_base_d = a_base;
          o_base_d = o_base;
        end
      end
      StClear: begin
        cnt_d = '0;
        if (m_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StLoadW;
        end
      end
      StLoadW: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = StWSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWSettle: begin
        if (cnt_q == CW'(MEM_LAT - 1)) begin
          state_d = StStream;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStream: begin
        if (cnt_q + CW'(1) == m_ext) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDrain: begin
        // o_wr_en high with wr_cnt_q == M means the M-th write is on the bus now.
        if (o_wr_en && wr_cnt_q == m_ext) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d  = StIdle;
      cnt_d    = '0;
      wr_cnt_d = '0;
      done_d   = 1'b0;
    end

    busy_d      = (state_d != StIdle);
    arr_clear_d = (state_d == StClear);
    w_rd_en_d   = (state_d == StLoadW);
    w_rd_addr_d = w_rd_en_d ? w_base_d + ADDR_W'(cnt_d) : '0;
    w_rd_row_d  = w_rd_en_d ? ROW_W'(cnt_d) : '0;
    a_rd_en_d   = (state_d == StStream);
    a_rd_addr_d = a_rd_en_d ? a_base_d + ADDR_W'(cnt_d) : '0;
    o_wr_en_d   = wr_pre && !abort;
    o_wr_addr_d = o_wr_en_d ? o_base_q + ADDR_W'(wr_cnt_q) : '0;
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_cnt_q   <= '0;
      m_q        <= '0;
      w_base_q   <= '0;
      a_base_q   <= '0;
      o_base_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      arr_clear  <= 1'b0;
      w_rd_en    <= 1'b0;
      w_rd_addr  <= '0;
      w_rd_row_q <= '0;
      a_rd_en    <= 1'b0;
      a_rd_addr  <= '0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      m_q        <= m_d;
      w_base_q   <= w_base_d;
      a_base_q   <= a_base_d;
      o_base_q   <= o_base_d;
      busy       <= busy_d;
      done       <= done_d;
      arr_clear  <= arr_clear_d;
      w_rd_en    <= w_rd_en_d;
      w_rd_addr  <= w_rd_addr_d;
      w_rd_row_q <= w_rd_row_d;
      a_rd_en    <= a_rd_en_d;
      a_rd_addr  <= a_rd_addr_d;
      o_wr_en    <= o_wr_en_d;
      o_wr_addr  <= o_wr_addr_d;
    end
  end

  // Weight latch and activation valid both trail their read strobes by the memory latency.
  tpu_valid_delay #(
    .DEPTH(MEM_LAT),
    .WIDTH(ROW_W + 2)
  ) u_rd_dly (
    .clk  (clk),
    .reset(reset),
    .clear(abort),
    .din  ({a_rd_en, w_rd_en, w_rd_row_q}),
    .dout ({arr_act_valid, arr_load_w, arr_w_row})
  );

  // Fed from the next-state read strobe so wr_pre leads o_wr_en by one cycle,
  // giving time to register the write address from the write counter.
  tpu_valid_delay #(
    .DEPTH(MEM_LAT + ARR_LAT),
    .WIDTH(1)
  ) u_wr_dly (
    .clk  (clk),
    .reset(reset),
    .clear(abort),
    .din  (a_rd_en_d),
    .dout (wr_pre)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench: per-cycle expected traces built from the job timing rules.
module tb_systolic_sequencer;

  localparam int unsigned N       = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned MEM_LAT = 1;
  localparam int          AL      = 2 * N - 1;
  localparam int          MAXC    = 320;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic [CNT_W-1:0]     num_rows;
  logic [ADDR_W-1:0]    w_base, a_base, o_base;
  logic                 busy, done, w_rd_en, a_rd_en, arr_clear, arr_load_w;
  logic                 arr_act_valid, o_wr_en;
  logic [ADDR_W-1:0]    w_rd_addr, a_rd_addr, o_wr_addr;
  logic [$clog2(N)-1:0] arr_w_row;

  always #5 clk = ~clk;

  systolic_sequencer #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_rows     (num_rows),
    .w_base       (w_base),
    .a_base       (a_base),
    .o_base       (o_base),
    .busy         (busy),
    .done         (done),
    .w_rd_en      (w_rd_en),
    .w_rd_addr    (w_rd_addr),
    .a_rd_en      (a_rd_en),
    .a_rd_addr    (a_rd_addr),
    .arr_clear    (arr_clear),
    .arr_load_w   (arr_load_w),
    .arr_w_row    (arr_w_row),
    .arr_act_valid(arr_act_valid),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr)
  );

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 arr_clear;
    logic                 w_rd_en;
    logic [ADDR_W-1:0]    w_rd_addr;
    logic                 arr_load_w;
    logic [$clog2(N)-1:0] arr_w_row;
    logic                 a_rd_en;
    logic [ADDR_W-1:0]    a_rd_addr;
    logic                 arr_act_valid;
    logic                 o_wr_en;
    logic [ADDR_W-1:0]    o_wr_addr;
  } obs_t;

  obs_t exp_tr [MAXC];
  int   n_checks = 0;
  int   n_fail   = 0;

  int                n_starts;
  int                start_c [4];
  int                start_m [4];
  logic [ADDR_W-1:0] start_w [4];
  logic [ADDR_W-1:0] start_a [4];
  logic [ADDR_W-1:0] start_o [4];

  function automatic obs_t sample();
    obs_t o;
    o.busy          = busy;
    o.done          = done;
    o.arr_clear     = arr_clear;
    o.w_rd_en       = w_rd_en;
    o.w_rd_addr     = w_rd_addr;
    o.arr_load_w    = arr_load_w;
    o.arr_w_row     = arr_w_row;
    o.a_rd_en       = a_rd_en;
    o.a_rd_addr     = a_rd_addr;
    o.arr_act_valid = arr_act_valid;
    o.o_wr_en       = o_wr_en;
    o.o_wr_addr     = o_wr_addr;
    return o;
  endfunction

  // Addresses and row index only matter while their strobe is expected.
  function automatic obs_t mask(input obs_t v, input obs_t refv);
    obs_t r = v;
    if (!refv.w_rd_en)    r.w_rd_addr = '0;
    if (!refv.a_rd_en)    r.a_rd_addr = '0;
    if (!refv.arr_load_w) r.arr_w_row = '0;
    if (!refv.o_wr_en)    r.o_wr_addr = '0;
    return r;
  endfunction

  // Cycles from start to the done cycle inclusive.
  function automatic int job_len(input int m);
    if (m == 0) return 3;
    return 2 + N + MEM_LAT + (m - 1) + MEM_LAT + AL + 2;
  endfunction

  task automatic clear_sched();
    n_starts = 0;
    for (int c = 0; c < MAXC; c++) exp_tr[c] = '0;
  endtask

  // Adds the expected activity of a job whose start strobe is in cycle t.
  task automatic add_job(input int t, input int m, input logic [ADDR_W-1:0] wb,
                         input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] ob);
    int s0, last;
    exp_tr[t+1].busy      = 1'b1;
    exp_tr[t+1].arr_clear = 1'b1;
    if (m == 0) begin
      exp_tr[t+2].done = 1'b1;
      return;
    end
    for (int k = 0; k < int'(N); k++) begin
      exp_tr[t+2+k].w_rd_en             = 1'b1;
      exp_tr[t+2+k].w_rd_addr           = ADDR_W'(wb + k);
      exp_tr[t+2+k+MEM_LAT].arr_load_w  = 1'b1;
      exp_tr[t+2+k+MEM_LAT].arr_w_row   = k[$clog2(N)-1:0];
    end
    s0 = t + 2 + N + MEM_LAT;
    for (int j = 0; j < m; j++) begin
      exp_tr[s0+j].a_rd_en                  = 1'b1;
      exp_tr[s0+j].a_rd_addr                = ADDR_W'(ab + j);
      exp_tr[s0+j+MEM_LAT].arr_act_valid    = 1'b1;
      exp_tr[s0+j+MEM_LAT+AL].o_wr_en       = 1'b1;
      exp_tr[s0+j+MEM_LAT+AL].o_wr_addr     = ADDR_W'(ob + j);
    end
    last = s0 + m - 1 + MEM_LAT + AL;
    for (int c = t + 1; c <= last; c++) exp_tr[c].busy = 1'b1;
    exp_tr[last+1].done = 1'b1;
  endtask

  task automatic sched_start(input int c, input int m, input logic [ADDR_W-1:0] wb,
                             input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] ob,
                             input bit accepted);
    start_c[n_starts] = c;
    start_m[n_starts] = m;
    start_w[n_starts] = wb;
    start_a[n_starts] = ab;
    start_o[n_starts] = ob;
    n_starts++;
    if (accepted) add_job(c, m, wb, ab, ob);
  endtask

  // Drives the schedule cycle by cycle and compares every cycle; after kill_at the
  // expected trace is all zero (addresses included when the kill is a reset).
  task automatic run_trace(input string name, input int ncyc, input int kill_at,
                           input bit kill_reset);
    obs_t o, e;
    bool_dummy: for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start    = 1'b0;
      abort    = 1'b0;
      reset    = 1'b0;
      num_rows = CNT_W'($urandom);
      w_base   = ADDR_W'($urandom);
      a_base   = ADDR_W'($urandom);
      o_base   = ADDR_W'($urandom);
      for (int i = 0; i < n_starts; i++) begin
        if (start_c[i] == c) begin
          start    = 1'b1;
          num_rows = CNT_W'(start_m[i]);
          w_base   = start_w[i];
          a_base   = start_a[i];
          o_base   = start_o[i];
        end
      end
      if (c == kill_at) begin
        if (kill_reset) reset = 1'b1;
        else            abort = 1'b1;
      end
      @(negedge clk);
      o = sample();
      e = (kill_at >= 0 && c > kill_at) ? obs_t'('0) : exp_tr[c];
      if (!(kill_reset && kill_at >= 0 && c > kill_at)) begin
        o = mask(o, e);
        e = mask(e, e);
      end
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, o, e);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    num_rows = 8'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      o = sample();
      n_checks++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h expected 0", c, o);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    o = sample();
    n_checks++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 0", o);
    end
  endtask

  task automatic test_nominal();
    clear_sched();
    sched_start(0, 3, 8'h10, 8'h20, 8'h40, 1'b1);
    run_trace("nominal", 22, -1, 1'b0);
  endtask

  task automatic test_zero_rows();
    clear_sched();
    sched_start(0, 0, 8'h10, 8'h20, 8'h40, 1'b1);
    run_trace("zero_rows", 10, -1, 1'b0);
  endtask

  task automatic test_wrap();
    clear_sched();
    sched_start(0, 3, 8'hFE, 8'hFE, 8'hFF, 1'b1);
    run_trace("wrap", 22, -1, 1'b0);
  endtask

  task automatic test_abort();
    clear_sched();
    sched_start(0, 3, 8'h10, 8'h20, 8'h40, 1'b1);
    run_trace("abort", 30, 9, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    clear_sched();
    sched_start(0, 3, 8'h10, 8'h20, 8'h40, 1'b0);
    run_trace("start_abort_idle", 12, 0, 1'b0);
  endtask

  task automatic test_busy_start();
    clear_sched();
    sched_start(0, 3, 8'h10, 8'h20, 8'h40, 1'b1);
    sched_start(5, 5, 8'h80, 8'h90, 8'hA0, 1'b0);
    sched_start(12, 2, 8'h81, 8'h91, 8'hA1, 1'b0);
    run_trace("busy_start", 22, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_sched();
    sched_start(0, 3, 8'h10, 8'h20, 8'h40, 1'b1);
    sched_start(18, 2, 8'h30, 8'h50, 8'h70, 1'b1);
    run_trace("back_to_back", 18 + job_len(2) + 2, -1, 1'b0);
  endtask

  task automatic test_reset_midjob();
    clear_sched();
    sched_start(0, 3, 8'h10, 8'h20, 8'h40, 1'b1);
    run_trace("reset_midjob", 30, 12, 1'b1);
    clear_sched();
    sched_start(0, 3, 8'h10, 8'h20, 8'h40, 1'b1);
    run_trace("after_reset", 22, -1, 1'b0);
  endtask

  task automatic test_random();
    int m;
    for (int t = 0; t < 6; t++) begin
      clear_sched();
      m = int'($urandom_range(1, 24));
      sched_start(0, m, ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 1'b1);
      run_trace("random", job_len(m) + 2, -1, 1'b0);
    end
  endtask

  task automatic test_max_rows();
    clear_sched();
    sched_start(0, 255, 8'h00, 8'h80, 8'hC0, 1'b1);
    run_trace("max_rows", job_len(255) + 2, -1, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    num_rows = '0;
    w_base   = '0;
    a_base   = '0;
    o_base   = '0;
    test_reset();
    test_nominal();
    test_zero_rows();
    test_wrap();
    test_abort();
    test_start_abort_idle();
    test_busy_start();
    test_back_to_back();
    test_reset_midjob();
    test_random();
    test_max_rows();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
Sequencer for the N×N weight-stationary systolic array behind the HPS/Avalon register interface. One command (base addresses plus row count) triggers the full job: clear the accumulators, load N weight rows, stream M activation rows, then write M result rows to the output buffer. It drives the read and write strobes for the weight, activation and output buffers, plus the array control strobes. It raises a one-cycle done pulse that software polls through a status PIO.

Parameters:
N, 4, array dimension (rows = columns)
ADDR_W, 8, buffer address width
CNT_W, 8, activation row-count width
MEM_LAT, 1, buffer read latency in cycles (≥1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
abort  in  1  synchronous job cancel
num_rows  in  CNT_W  M, activation rows; sampled with start
w_base  in  ADDR_W  weight buffer base; sampled with start
a_base  in  ADDR_W  activation buffer base; sampled with start
o_base  in  ADDR_W  output buffer base; sampled with start
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
w_rd_en  out  1  weight buffer read strobe
w_rd_addr  out  ADDR_W  weight read address
a_rd_en  out  1  activation buffer read strobe
a_rd_addr  out  ADDR_W  activation read address
arr_clear  out  1  clear array accumulators
arr_load_w  out  1  array latches the returning weight row
arr_w_row  out  $clog2(N)  index of the weight row being latched
arr_act_valid  out  1  returning activation row valid at the array input
o_wr_en  out  1  output buffer write strobe
o_wr_addr  out  ADDR_W  output write address

Behaviour:
- All outputs are registered. During reset every output is 0, the state is IDLE and the delay lines are cleared.
- ARR_LAT = 2N-1 is the array's skew plus accumulation latency, measured from arr_act_valid to a valid result row.
- FSM states: IDLE, CLEAR, LOAD_W, W_SETTLE, STREAM, DRAIN.
- IDLE
  - start=1 latches num_rows and the three bases, then moves to CLEAR.
  - start is ignored in every other state.
- CLEAR
  - Lasts 1 cycle with arr_clear=1.
  - Goes to LOAD_W, or to IDLE with done=1 if M=0 (no reads or writes are issued).
- LOAD_W
  - Lasts N cycles. In cycle k: w_rd_en=1, w_rd_addr=w_base+k.
  - arr_load_w and arr_w_row=k follow MEM_LAT cycles later, through a delay line.
- W_SETTLE
  - Lasts MEM_LAT cycles so the last weight row lands before any activation is issued.
- STREAM
  - Lasts M cycles. In cycle j: a_rd_en=1, a_rd_addr=a_base+j.
  - arr_act_valid equals a_rd_en delayed by MEM_LAT.
  - o_wr_en equals a_rd_en delayed by MEM_LAT+ARR_LAT, with o_wr_addr=o_base+j, produced by the write counter.
- DRAIN
  - Waits until the M-th o_wr_en has been issued.
  - The next cycle returns to IDLE with done=1.
- busy is 1 from CLEAR through the cycle of the last o_wr_en; it is 0 in the done cycle.
- The done cycle is IDLE, so a start in that cycle is accepted.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is legal and silent.
- The maximum M is 2^CNT_W-1. Row counters are CNT_W+1 bits wide and must not overflow.
- abort
  - Valid in any non-IDLE state.
  - Next cycle: state is IDLE, busy=0, and all strobes and delay lines are cleared.
  - done is not pulsed; no further writes are issued.
- start and abort together in IDLE: abort wins and start is ignored.
- Reset mid-job behaves as abort, except that reset also clears the latched command.

Decomposition:
- Package tpu_seq_pkg holds:
  - the state enum;
  - the arr_lat(N) function;
  - the shared widths (ADDR_W and CNT_W defaults).
- Sub-module tpu_valid_delay
  - A parameterised (DEPTH, WIDTH) shift-register delay line with synchronous clear.
  - Instantiated for the arr_load_w/arr_w_row path (DEPTH=MEM_LAT) and the o_wr_en path (DEPTH=MEM_LAT+ARR_LAT).
  - Cleared by abort and by reset.

Test Plan:
- Nominal job. Setup: N=4, MEM_LAT=1, M=3, w_base=0x10, a_base=0x20, o_base=0x40; start at cycle 0.
  - arr_clear at c1.
  - w_rd c2–c5, addresses 0x10–0x13.
  - arr_load_w c3–c6, rows 0–3.
  - a_rd c7–c9, addresses 0x20–0x22.
  - arr_act_valid c8–c10.
  - o_wr c15–c17, addresses 0x40–0x42.
  - done at c18; busy=1 for c1–c17.
- Zero rows: M=0 start at c0 -> arr_clear c1, done c2, no rd/wr strobes at all.
- Wrap-around: a_base=0xFE, o_base=0xFF, M=3 -> a_rd_addr 0xFE, 0xFF, 0x00; o_wr_addr 0xFF, 0x00, 0x01.
- Abort and busy start:
  - abort at c9 of the nominal job -> busy=0 and all strobes 0 from c10; no o_wr_en and no done ever.
  - A start during busy is ignored: the bases stay unchanged.
- Back-to-back: a second start in the done cycle (c18) -> arr_clear at c19, using the new bases.
- Reset: reset at c12 -> every output is 0 at c13 and stays 0; the first start afterwards runs nominally.
